// File: rtl/ssd_pkg.sv
// Seven-segment encoding constants and nibble encoder shared by the scan controller.
// All patterns are held in active-low form {a,b,c,d,e,f,g}, bit6 = a.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, DIGITS BCD nibbles out,
// plus a flag for values that do not fit in DIGITS decimal digits.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 13,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned NW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int unsigned d);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < d; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  // add-3 correction on every nibble >= 5, then shift in the next binary bit
  function automatic logic [NW-1:0] dabble(input logic [NW-1:0] b, input logic bit_in);
    logic [NW-1:0] t;
    t = b;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    return {t[NW-2:0], bit_in};
  endfunction

  logic [BIN_W-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             run;

  // The first shift is folded into the start cycle so the conversion spans exactly BIN_W cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      sh  <= bin_in << 1;
      bcd <= dabble('0, bin_in[BIN_W-1]);
      cnt <= CW'(BIN_W - 1);
      run <= 1'b1;
      ovf <= (64'(bin_in) >= LIMIT);
    end else if (run) begin
      if (cnt != '0) begin
        bcd <= dabble(bcd, sh[BIN_W-1]);
        sh  <= sh << 1;
        cnt <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment controller: load/busy capture, decimal or hex conversion,
// atomic display register update, free-running digit scan with registered pin outputs.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BIN_W        = 13,
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  num,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_out,
  output logic              dp_out
);

  localparam int unsigned NW  = 4 * DIGITS;
  localparam int unsigned IW  = $clog2(DIGITS);
  localparam logic        INV = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_DEC, ST_HEX} conv_state_t;

  conv_state_t       state;
  logic [63:0]       num_ext;
  logic [NW-1:0]     hex_val;
  logic              hex_ovf;
  logic [NW-1:0]     disp_nib;
  logic              disp_ovf;
  logic              disp_valid;
  logic              bcd_start;
  logic              bcd_done;
  logic [NW-1:0]     bcd_val;
  logic              bcd_ovf;

  assign num_ext   = 64'(num);
  assign bcd_start = (state == ST_IDLE) && load && !hex_mode;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bcd_start),
    .bin_in (num),
    .done   (bcd_done),
    .bcd    (bcd_val),
    .ovf    (bcd_ovf)
  );

  // Handshake FSM: accept when idle, wait for conversion, commit result to display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      hex_val    <= '0;
      hex_ovf    <= 1'b0;
      disp_nib   <= '0;
      disp_ovf   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (load) begin
          busy <= 1'b1;
          if (hex_mode) begin
            state   <= ST_HEX;
            hex_val <= num_ext[NW-1:0];
            hex_ovf <= |(num_ext >> NW);
          end else begin
            state <= ST_DEC;
          end
        end
        ST_DEC: if (bcd_done) begin
          disp_nib   <= bcd_val;
          disp_ovf   <= bcd_ovf;
          disp_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_HEX: begin
          disp_nib   <= hex_val;
          disp_ovf   <= hex_ovf;
          disp_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [REFRESH_BITS-1:0] pre;
  logic [IW-1:0]           idx;

  // Free-running scan: prescaler wrap steps the digit index from leftmost down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= IW'(DIGITS - 1);
    end else begin
      pre <= pre + 1'b1;
      if (&pre) idx <= (idx == '0) ? IW'(DIGITS - 1) : idx - 1'b1;
    end
  end

  logic [3:0]        cur_nib;
  logic              nz_at_or_above;
  logic [6:0]        seg_pat;
  logic              dp_on;
  logic [DIGITS-1:0] anode_oh;

  // Pattern selection for the digit currently being scanned (active-low form)
  always_comb begin
    cur_nib        = disp_nib[idx*4 +: 4];
    nz_at_or_above = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++)
      if (j >= 32'(idx) && disp_nib[j*4 +: 4] != 4'd0) nz_at_or_above = 1'b1;
    anode_oh = DIGITS'(1) << idx;
    seg_pat  = SEG_BLANK;
    dp_on    = 1'b0;
    if (disp_valid) begin
      dp_on = dp_mask[idx];
      if (disp_ovf)
        seg_pat = SEG_DASH;
      else if (blank_lz && idx != '0 && !nz_at_or_above)
        seg_pat = SEG_BLANK;
      else
        seg_pat = seg_encode(cur_nib);
    end
  end

  // Registered pin drivers with polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Anode   <= {DIGITS{INV}};
      LED_out <= {7{INV}};
      dp_out  <= INV;
    end else begin
      Anode   <= anode_oh ^ {DIGITS{INV}};
      LED_out <= INV ? seg_pat : ~seg_pat;
      dp_out  <= INV ? ~dp_on : dp_on;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: three configurations sharing clock and reset.
module tb_ssd_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int unsigned ecount;

  logic        load_i [3];
  logic [31:0] num_i  [3];
  logic        hex_i  [3];
  logic        blz_i  [3];
  logic [7:0]  dpm_i  [3];
  logic        busy_o [3];
  logic [6:0]  led_o  [3];
  logic        dp_o   [3];
  logic [3:0]  an0, an1;
  logic [5:0]  an2;

  ssd_scan_ctrl #(.DIGITS(4), .BIN_W(13), .REFRESH_BITS(2), .ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load_i[0]), .num(num_i[0][12:0]), .hex_mode(hex_i[0]),
    .blank_lz(blz_i[0]), .dp_mask(dpm_i[0][3:0]), .busy(busy_o[0]), .Anode(an0),
    .LED_out(led_o[0]), .dp_out(dp_o[0]));

  ssd_scan_ctrl #(.DIGITS(4), .BIN_W(14), .REFRESH_BITS(2), .ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load_i[1]), .num(num_i[1][13:0]), .hex_mode(hex_i[1]),
    .blank_lz(blz_i[1]), .dp_mask(dpm_i[1][3:0]), .busy(busy_o[1]), .Anode(an1),
    .LED_out(led_o[1]), .dp_out(dp_o[1]));

  ssd_scan_ctrl #(.DIGITS(6), .BIN_W(20), .REFRESH_BITS(2), .ACTIVE_LOW(0)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load_i[2]), .num(num_i[2][19:0]), .hex_mode(hex_i[2]),
    .blank_lz(blz_i[2]), .dp_mask(dpm_i[2][5:0]), .busy(busy_o[2]), .Anode(an2),
    .LED_out(led_o[2]), .dp_out(dp_o[2]));

  // clock edges since reset release; drives the expected scan position
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;

  function automatic int dig(input int w);
    return (w == 2) ? 6 : 4;
  endfunction

  function automatic int binw(input int w);
    return (w == 0) ? 13 : (w == 1) ? 14 : 20;
  endfunction

  // observed outputs normalised to logical form: anode 1=lit, segments active-low, dp 1=lit
  function automatic logic [7:0] act_an(input int w);
    case (w)
      0:       return {4'b0, ~an0};
      1:       return {4'b0, ~an1};
      default: return {2'b0, an2};
    endcase
  endfunction

  function automatic logic [6:0] act_led(input int w);
    return (w == 2) ? ~led_o[w] : led_o[w];
  endfunction

  function automatic logic act_dp(input int w);
    return (w == 2) ? dp_o[w] : ~dp_o[w];
  endfunction

  function automatic logic [6:0] seg_of(input longint unsigned v);
    case (v)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;  6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100; 10: return 7'b0001000; 11: return 7'b1100000;
     12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  // Reference: digit k of val in the chosen base, by division
  function automatic logic [7:0][6:0] model_segs(input int unsigned val, input bit hex,
                                                 input bit blz, input int d);
    logic [7:0][6:0] r;
    longint unsigned base, lim, pw;
    base = hex ? 16 : 10;
    lim  = 1;
    for (int i = 0; i < d; i++) lim = lim * base;
    pw = 1;
    for (int k = 0; k < 8; k++) begin
      r[k] = 7'b1111111;
      if (k < d) begin
        if (longint'(val) >= lim)               r[k] = 7'b1111110;
        else if (blz && k > 0 && longint'(val) < pw) r[k] = 7'b1111111;
        else                                    r[k] = seg_of((longint'(val) / pw) % base);
      end
      pw = pw * base;
    end
    return r;
  endfunction

  function automatic logic [7:0][6:0] pk(input logic [6:0] s5, s4, s3, s2, s1, s0);
    return {7'h7f, 7'h7f, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // one full scan: anode order from elapsed cycles, segments/dp against expectation
  task automatic check_disp(input int w, input logic [7:0][6:0] segs, input logic [7:0] dpm,
                            input string nm);
    int d, n, k;
    d = dig(w);
    for (int c = 0; c < 4 * d; c++) begin
      @(negedge clk);
      n = int'(ecount);
      k = d - 1 - (((n - 1) / 4) % d);
      chk($sformatf("%s.anode", nm), 32'(act_an(w)), 32'(8'd1 << k));
      chk($sformatf("%s.seg%0d", nm, k), 32'(act_led(w)), 32'(segs[k]));
      chk($sformatf("%s.dp%0d", nm, k), 32'(act_dp(w)), 32'(dpm[k]));
    end
  endtask

  task automatic wait_idle(input int w, input int exp_cyc, input string nm);
    int n;
    n = 0;
    while (busy_o[w] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s.busy_cycles", nm), 32'(n), 32'(exp_cyc));
  endtask

  task automatic do_load(input int w, input int unsigned val, input bit hex, input int exp_cyc,
                         input string nm);
    @(negedge clk);
    load_i[w] = 1'b1;
    num_i[w]  = val;
    hex_i[w]  = hex;
    @(negedge clk);
    load_i[w] = 1'b0;
    chk($sformatf("%s.busy_rise", nm), 32'(busy_o[w]), 32'd1);
    wait_idle(w, exp_cyc, nm);
  endtask

  typedef struct {
    int              w;
    int unsigned     val;
    bit              hex;
    bit              blz;
    logic [7:0]      dpm;
    int              bcyc;
    logic [7:0][6:0] segs;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] B;
    logic [6:0] D;
    int w;
    int unsigned v, msk;
    bit h, bz;
    B = 7'b1111111;
    D = 7'b1111110;
    vt[0] = '{0, 1234,   1'b0, 1'b0, 8'h00, 13, pk(B, B, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100)};
    vt[1] = '{0, 7,      1'b0, 1'b1, 8'h00, 13, pk(B, B, B, B, B, 7'b0001111)};
    vt[2] = '{0, 7,      1'b0, 1'b0, 8'h01, 13, pk(B, B, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111)};
    vt[3] = '{0, 0,      1'b0, 1'b1, 8'h00, 13, pk(B, B, B, B, B, 7'b0000001)};
    vt[4] = '{0, 'h1AF3, 1'b1, 1'b0, 8'h04, 1,  pk(B, B, 7'b1001111, 7'b0001000, 7'b0111000, 7'b0000110)};
    vt[5] = '{1, 10000,  1'b0, 1'b0, 8'h09, 14, pk(B, B, D, D, D, D)};
    vt[6] = '{2, 1234,   1'b0, 1'b1, 8'h20, 20, pk(B, B, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100)};
    vt[7] = '{2, 'hB0C0, 1'b1, 1'b1, 8'h00, 1,  pk(B, B, 7'b1100000, 7'b0000001, 7'b0110001, 7'b0000001)};

    for (int i = 0; i < 3; i++) begin
      load_i[i] = 1'b0; num_i[i] = '0; hex_i[i] = 1'b0; blz_i[i] = 1'b0; dpm_i[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d.busy", i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("reset%0d.anode", i), 32'(act_an(i)), 32'd0);
      chk($sformatf("reset%0d.seg", i), 32'(act_led(i)), 32'h7f);
      chk($sformatf("reset%0d.dp", i), 32'(act_dp(i)), 32'd0);
    end
    rst_n = 1'b1;

    // invalid display before any completion: anodes scan, segments dark
    check_disp(0, pk(B, B, B, B, B, B), 8'h00, "invalid");

    for (int i = 0; i < 8; i++) begin
      blz_i[vt[i].w] = vt[i].blz;
      dpm_i[vt[i].w] = vt[i].dpm;
      do_load(vt[i].w, vt[i].val, vt[i].hex, vt[i].bcyc, $sformatf("vec%0d", i));
      check_disp(vt[i].w, vt[i].segs, vt[i].dpm, $sformatf("vec%0d", i));
    end

    // second load while busy is dropped, not queued
    blz_i[0] = 1'b0;
    dpm_i[0] = 8'h00;
    @(negedge clk);
    load_i[0] = 1'b1; num_i[0] = 42; hex_i[0] = 1'b0;
    @(negedge clk);
    load_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    load_i[0] = 1'b1; num_i[0] = 99;
    @(negedge clk);
    load_i[0] = 1'b0;
    wait_idle(0, 9, "ignore");
    repeat (2) @(negedge clk);
    chk("ignore.no_requeue", 32'(busy_o[0]), 32'd0);
    check_disp(0, model_segs(42, 1'b0, 1'b0, 4), 8'h00, "ignore");

    // reset in the middle of a conversion
    @(negedge clk);
    load_i[0] = 1'b1; num_i[0] = 555;
    @(negedge clk);
    load_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.busy", 32'(busy_o[0]), 32'd0);
    chk("midreset.seg", 32'(act_led(0)), 32'h7f);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset.busy_after", 32'(busy_o[0]), 32'd0);
    check_disp(0, pk(B, B, B, B, B, B), 8'h00, "midreset");

    // randomized loads against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      w   = int'($urandom_range(0, 2));
      msk = (32'd1 << binw(w)) - 1;
      v   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 120) : ($urandom & msk);
      h   = 1'($urandom_range(0, 1));
      bz  = 1'($urandom_range(0, 1));
      blz_i[w] = bz;
      dpm_i[w] = 8'($urandom);
      do_load(w, v, h, h ? 1 : binw(w), $sformatf("rnd%0d", i));
      check_disp(w, model_segs(v, h, bz, dig(w)), dpm_i[w], $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
